// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter
// Packet-granular round-robin arbiter sharing one AXI-Stream sink among
// num_src burst masters. The grant is locked from a packet's first beat to
// its tlast beat, then priority rotates. A packet reaching max_len beats is
// forcibly terminated and flagged on len_err.
//
// Ports:
//   clk, rst        clock, synchronous active-low reset
//   s_data/s_valid/s_tlast/s_ready  per-source AXI-Stream slave side
//   m_data/m_valid/m_tlast/m_ready  shared AXI-Stream master side
//   grant           one-hot current grant (zero when idle)
//   busy            high while a packet is being transferred
//   len_err         one-cycle pulse after a packet was truncated
module axis_rr_arbiter #(
  parameter int data_width = 32,
  parameter int num_src    = 4,
  parameter int max_len    = 16,
  parameter int cnt_width  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [num_src*data_width-1:0] s_data,
  input  logic [num_src-1:0]            s_valid,
  input  logic [num_src-1:0]            s_tlast,
  output logic [num_src-1:0]            s_ready,
  output logic [data_width-1:0]         m_data,
  output logic                          m_valid,
  output logic                          m_tlast,
  input  logic                          m_ready,
  output logic [num_src-1:0]            grant,
  output logic                          busy,
  output logic                          len_err
);

  localparam int PW = (num_src > 1) ? $clog2(num_src) : 1;

  typedef enum logic {IDLE, XFER} state_e;

  state_e               state_q, state_d;
  logic [num_src-1:0]   grant_q, grant_d;
  logic [PW-1:0]        last_q, last_d;   // doubles as the granted index in XFER
  logic [cnt_width-1:0] cnt_q, cnt_d;
  logic                 len_err_q, len_err_d;

  logic [PW-1:0]        cand;
  logic [PW-1:0]        sel_idx;
  logic                 sel_found;
  logic                 forced;
  logic                 hs;

  // Rotated priority search starting one past the last granted source.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = last_q;
    cand      = '0;
    for (int i = 1; i <= num_src; i++) begin
      cand = PW'((int'(last_q) + i) % num_src);
      if (!sel_found && s_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Combinational datapath while a grant is held. s_ready is gated by reset
  // so nothing is accepted from a source while the block is being reset.
  always_comb begin
    m_data  = '0;
    m_valid = 1'b0;
    m_tlast = 1'b0;
    s_ready = '0;
    forced  = 1'b0;
    if (state_q == XFER) begin
      m_data  = s_data[int'(last_q)*data_width +: data_width];
      m_valid = s_valid[last_q];
      forced  = (cnt_q == cnt_width'(max_len - 1));
      m_tlast = s_tlast[last_q] | forced;
      if (rst) s_ready[last_q] = m_ready;
    end
  end

  assign hs = m_valid & m_ready;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
    if (state_q == IDLE) begin
      if (sel_found) begin
        state_d          = XFER;
        grant_d          = '0;
        grant_d[sel_idx] = 1'b1;
        last_d           = sel_idx;
        cnt_d            = '0;
      end
    end else if (hs) begin
      if (m_tlast) begin
        state_d   = IDLE;
        grant_d   = '0;
        cnt_d     = '0;
        // Truncated packet: the source itself did not mark this beat last.
        len_err_d = ~s_tlast[last_q];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= PW'(num_src - 1);
      cnt_q     <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = (state_q == XFER);
  assign len_err = len_err_q;

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Testbench for axis_rr_arbiter: per-source beat queues drive the DUT; the
// expected sink beats (data, tlast, truncation flag) are pushed to per-source
// scoreboard queues when packets are issued, and a negedge monitor tracks the
// packet-level arbitration (round-robin over requesting sources, one idle
// cycle between packets) and pops/compares on every sink handshake.
module tb_axis_rr_arbiter;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int ML = 16;
  localparam int CW = 5;

  typedef struct packed {logic [DW-1:0] d; logic l;} beat_t;
  typedef struct packed {logic [DW-1:0] d; logic tl; logic err;} exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS*DW-1:0]  s_data;
  logic [NS-1:0]     s_valid, s_tlast, s_ready;
  logic [DW-1:0]     m_data;
  logic              m_valid, m_tlast, m_ready;
  logic [NS-1:0]     grant;
  logic              busy, len_err;

  axis_rr_arbiter #(.data_width(DW), .num_src(NS), .max_len(ML), .cnt_width(CW)) dut (
    .clk(clk), .rst(rst),
    .s_data(s_data), .s_valid(s_valid), .s_tlast(s_tlast), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_tlast(m_tlast), .m_ready(m_ready),
    .grant(grant), .busy(busy), .len_err(len_err)
  );

  always #5 clk = ~clk;

  beat_t src_q[NS][$];
  exp_t  exp_q[NS][$];
  int    seg_cnt[NS];
  int    pkt_id = 0;
  int    vpct = 100;
  int    rdy_mode = 0;
  int    n_vec = 0;
  int    n_err = 0;

  // monitor model state
  bit    mb = 1'b0;
  int    mg = 0;
  int    ml = NS - 1;
  bit    err_cur = 1'b0;
  bit    err_nxt = 1'b0;
  int    rst_cnt = 0;
  exp_t  me;
  logic [NS-1:0] meg, mer;
  int    mp;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(int last, logic [NS-1:0] v);
    for (int i = 1; i <= NS; i++)
      if (v[(last + i) % NS]) return (last + i) % NS;
    return -1;
  endfunction

  // Queue a packet on source k; expected sink view is derived from the
  // rule that a beat is last if the source says so or it is the max_len-th
  // beat since the source's previous sink-side tlast.
  task automatic send_pkt(int k, int len);
    beat_t b;
    exp_t  e;
    bit    forced;
    for (int j = 0; j < len; j++) begin
      b.d = {8'(k), 8'(pkt_id), 16'(j)};
      b.l = (j == len - 1);
      src_q[k].push_back(b);
      forced  = (seg_cnt[k] == ML - 1);
      e.d     = b.d;
      e.tl    = b.l | forced;
      e.err   = forced & ~b.l;
      seg_cnt[k] = e.tl ? 0 : seg_cnt[k] + 1;
      exp_q[k].push_back(e);
    end
    pkt_id++;
  endtask

  task automatic drive();
    for (int k = 0; k < NS; k++) begin
      if (src_q[k].size() > 0) begin
        s_valid[k] = ($urandom_range(99) < vpct);
        s_data[k*DW +: DW] = src_q[k][0].d;
        s_tlast[k] = src_q[k][0].l;
      end else begin
        s_valid[k] = 1'b0;
        s_data[k*DW +: DW] = '0;
        s_tlast[k] = 1'b0;
      end
    end
    case (rdy_mode)
      1:       m_ready = ~m_ready;
      2:       m_ready = ($urandom_range(3) != 0);
      default: m_ready = 1'b1;
    endcase
  endtask

  task automatic step();
    logic [NS-1:0] hsk;
    @(negedge clk);
    hsk = s_valid & s_ready;
    @(posedge clk);
    #1;
    for (int k = 0; k < NS; k++)
      if (hsk[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    drive();
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < NS; k++) if (src_q[k].size() > 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(string nm);
    int n = 0;
    while ((!all_empty() || mb) && n < 3000) begin
      step();
      n++;
    end
    chk({nm, "_drained"}, (n < 3000), 1);
    for (int k = 0; k < NS; k++) chk({nm, "_exp_left"}, exp_q[k].size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) step();
    for (int k = 0; k < NS; k++) begin
      src_q[k].delete();
      exp_q[k].delete();
      seg_cnt[k] = 0;
    end
  endtask

  task automatic release_rst();
    drive();
    rst = 1'b1;
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_s_ready", s_ready, '0);
      if (rst_cnt > 0) begin
        chk("rst_grant", grant, '0);
        chk("rst_busy", busy, 0);
        chk("rst_len_err", len_err, 0);
      end
      rst_cnt++;
      mb = 1'b0;
      ml = NS - 1;
      err_cur = 1'b0;
    end else begin
      rst_cnt = 0;
      err_nxt = 1'b0;
      meg = '0;
      if (mb) meg[mg] = 1'b1;
      chk("grant", grant, meg);
      chk("busy", busy, mb);
      chk("len_err", len_err, err_cur);
      if (mb) begin
        chk("m_valid", m_valid, s_valid[mg]);
        mer = '0;
        if (m_ready) mer[mg] = 1'b1;
        chk("s_ready", s_ready, mer);
        if (s_valid[mg] && m_ready) begin
          chk("exp_avail", (exp_q[mg].size() > 0), 1);
          if (exp_q[mg].size() > 0) begin
            me = exp_q[mg].pop_front();
            chk("m_data", m_data, me.d);
            chk("m_tlast", m_tlast, me.tl);
            if (me.tl) begin
              mb = 1'b0;
              err_nxt = me.err;
            end
          end
        end
      end else begin
        chk("idle_m_valid", m_valid, 0);
        chk("idle_s_ready", s_ready, '0);
        chk("idle_m_tlast", m_tlast, 0);
        chk("idle_m_data", m_data, '0);
        mp = rr_pick(ml, s_valid);
        if (mp >= 0) begin
          mb = 1'b1;
          mg = mp;
          ml = mp;
        end
      end
      err_cur = err_nxt;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    s_valid = '0;
    s_tlast = '0;
    s_data = '0;
    m_ready = 1'b1;
    for (int k = 0; k < NS; k++) seg_cnt[k] = 0;
    repeat (3) step();
    release_rst();

    // single source 2, 16 beats, tlast on the final beat only
    send_pkt(2, 16);
    drive();
    drain("single");

    // backpressure on a source-1 packet
    rdy_mode = 1;
    send_pkt(1, 6);
    drive();
    drain("backpr");
    rdy_mode = 0;

    // round robin from reset: order 0,1,2,3,0,...
    do_reset();
    release_rst();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < NS; k++) send_pkt(k, 4);
    drive();
    drain("rr");

    // truncation: source 0 overruns max_len while others wait
    do_reset();
    release_rst();
    send_pkt(0, 20);
    send_pkt(1, 3);
    send_pkt(2, 3);
    drive();
    drain("trunc");

    // mid-packet reset on source 3
    do_reset();
    release_rst();
    send_pkt(3, 10);
    drive();
    for (int n = 0; n < 200 && exp_q[3].size() > 4; n++) step();
    chk("midrst_progress", exp_q[3].size(), 4);
    do_reset();
    send_pkt(0, 3);
    send_pkt(3, 3);
    release_rst();
    drain("midrst");

    // randomized traffic with valid gaps and random backpressure
    do_reset();
    release_rst();
    vpct = 70;
    rdy_mode = 2;
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < NS; k++)
        if ($urandom_range(19) == 0 && src_q[k].size() < 30)
          send_pkt(k, int'($urandom_range(1, 24)));
      step();
    end
    vpct = 100;
    rdy_mode = 0;
    drain("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
